// File: rtl/uabc_msg_sequencer_if.sv
// Switch-side bundle of the letter-scroller sequencer.
// Raw board inputs travel towards the sequencer; the letter index, the
// advance pulse and the FSM state travel back out.
interface uabc_msg_sequencer_if;

   // There is no valid/ready pairing on this bundle. The raw inputs are
   // asynchronous levels that the sequencer samples on every clock.
   // letter_idx and state are registered levels that are valid every cycle.
   // advance is a registered one-cycle strobe that marks the cycle in which
   // letter_idx first shows an advanced value. No back-pressure exists.
   logic       run_sw;
   logic       pause_sw;
   logic       step_btn;
   logic       fast_sw;
   logic [4:0] letter_idx;
   logic       advance;
   logic [1:0] state;

   // Board or bench side: drives the switches and observes the sequencer.
   modport master (
      output run_sw,
      output pause_sw,
      output step_btn,
      output fast_sw,
      input  letter_idx,
      input  advance,
      input  state
   );

   // Sequencer side.
   modport slave (
      input  run_sw,
      input  pause_sw,
      input  step_btn,
      input  fast_sw,
      output letter_idx,
      output advance,
      output state
   );

endinterface

// File: rtl/uabc_msg_sequencer.sv
// Upstream stage of the 7-segment letter scroller.
// The module synchronizes and debounces the four board inputs. It then
// runs the IDLE/RUN/PAUSE FSM and the speed prescaler, and produces the
// letter index that the segment stage decodes.
module uabc_msg_sequencer #(
   parameter int TICK_DIV        = 5_000_000,
   parameter int DEBOUNCE_CYCLES = 10_000,
   parameter int LAST_IDX        = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ena,
   uabc_msg_sequencer_if.slave       sig
);

   // FSM encoding. 2'b11 is never produced.
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_PAUSE = 2'b10;

   // Bit positions of the four conditioned inputs.
   localparam int I_RUN   = 0;
   localparam int I_PAUSE = 1;
   localparam int I_STEP  = 2;
   localparam int I_FAST  = 3;
   localparam int N_IN    = 4;

   localparam int DW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam int PW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV + 1);

   // The counter accepts a change on the edge where it would reach
   // DEBOUNCE_CYCLES. A clean change therefore lands exactly
   // DEBOUNCE_CYCLES edges after it leaves the synchronizer.
   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PW-1:0] LIM_SLOW = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] LIM_FAST = PW'(TICK_DIV / 2 - 1);
   localparam logic [4:0]    IDX_LAST = 5'(LAST_IDX);

   // Raw pins, gathered so that every input gets identical conditioning.
   logic [N_IN-1:0] raw;
   assign raw = {sig.fast_sw, sig.step_btn, sig.pause_sw, sig.run_sw};

   // ------------------------------------------------------------------
   // Synchronizers and debouncers
   // ------------------------------------------------------------------
   logic [N_IN-1:0] sync1;
   logic [N_IN-1:0] sync2;
   logic [N_IN-1:0] db;
   logic [N_IN-1:0] db_nxt;
   logic [DW-1:0]   db_cnt     [N_IN];
   logic [DW-1:0]   db_cnt_nxt [N_IN];

   // Two-flop synchronizers. These keep running while ena is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Debounce step: count consecutive disagreeing samples, then accept.
   always_comb begin
      for (int i = 0; i < N_IN; i++) begin
         db_nxt[i]     = db[i];
         db_cnt_nxt[i] = db_cnt[i];
         if (ena) begin
            if (sync2[i] == db[i]) begin
               db_cnt_nxt[i] = '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db_nxt[i]     = sync2[i];
               db_cnt_nxt[i] = '0;
            end else begin
               db_cnt_nxt[i] = db_cnt[i] + DW'(1);
            end
         end
      end
   end

   // Debounced values and their stability counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db <= '0;
         for (int i = 0; i < N_IN; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         db <= db_nxt;
         for (int i = 0; i < N_IN; i++) begin
            db_cnt[i] <= db_cnt_nxt[i];
         end
      end
   end

   // Downstream logic reads the value being accepted this cycle. The FSM
   // therefore moves on the same edge that the debounced register updates,
   // which keeps the pin-to-state latency equal to the debounce latency.
   logic run_db;
   logic pause_db;
   logic fast_db;
   logic step_rise;

   assign run_db    = db_nxt[I_RUN];
   assign pause_db  = db_nxt[I_PAUSE];
   assign fast_db   = db_nxt[I_FAST];
   // When ena is low, db_nxt equals db, so no rise can be seen.
   assign step_rise = db_nxt[I_STEP] & ~db[I_STEP];

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   logic [1:0] state_q;
   logic [1:0] state_nxt;

   // Next state. Losing run_db wins over every other condition.
   always_comb begin
      state_nxt = state_q;
      if (ena) begin
         if (!run_db) begin
            state_nxt = ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE:  state_nxt = ST_RUN;
               ST_RUN:   if (pause_db)  state_nxt = ST_PAUSE;
               ST_PAUSE: if (!pause_db) state_nxt = ST_RUN;
               default:  state_nxt = ST_IDLE;
            endcase
         end
      end
   end

   // ------------------------------------------------------------------
   // Prescaler
   // ------------------------------------------------------------------
   logic [PW-1:0] pre_cnt;
   logic [PW-1:0] pre_cnt_nxt;
   logic [PW-1:0] pre_lim;
   logic          tick;

   // The compare uses >=. If the count is already past a limit that has
   // just shortened, it still ticks at once and wraps.
   assign pre_lim = fast_db ? LIM_FAST : LIM_SLOW;
   assign tick    = ena && (state_q == ST_RUN) && (pre_cnt >= pre_lim);

   // Count only while staying in RUN. Any entry into RUN starts from 0.
   always_comb begin
      pre_cnt_nxt = pre_cnt;
      if (ena) begin
         if ((state_q != ST_RUN) || (state_nxt != ST_RUN)) begin
            pre_cnt_nxt = '0;
         end else if (tick) begin
            pre_cnt_nxt = '0;
         end else begin
            pre_cnt_nxt = pre_cnt + PW'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Letter index
   // ------------------------------------------------------------------
   logic [4:0] letter_q;
   logic [4:0] letter_nxt;
   logic       advance_q;
   logic       advance_nxt;

   // Wrap from the last letter back to the first. Index 0 (blank) is
   // reachable only through IDLE.
   function automatic logic [4:0] next_letter(input logic [4:0] cur);
      return (cur == IDX_LAST) ? 5'd1 : cur + 5'd1;
   endfunction

   // Letter update. Leaving for IDLE discards any tick or step arriving
   // in the same cycle. A tick that coincides with RUN->PAUSE still counts.
   always_comb begin
      letter_nxt  = letter_q;
      advance_nxt = 1'b0;
      if (ena) begin
         if (state_nxt == ST_IDLE) begin
            letter_nxt = 5'd0;
         end else if (state_q == ST_IDLE) begin
            letter_nxt  = 5'd1;
            advance_nxt = 1'b1;
         end else if (((state_q == ST_RUN) && tick) ||
                      ((state_q == ST_PAUSE) && step_rise)) begin
            letter_nxt  = next_letter(letter_q);
            advance_nxt = 1'b1;
         end
      end
   end

   // Registers for the FSM, prescaler and letter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pre_cnt   <= '0;
         letter_q  <= 5'd0;
         advance_q <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         pre_cnt   <= pre_cnt_nxt;
         letter_q  <= letter_nxt;
         advance_q <= advance_nxt;
      end
   end

   assign sig.letter_idx = letter_q;
   assign sig.advance    = advance_q;
   assign sig.state      = state_q;

endmodule

// File: tb/tb_uabc_msg_sequencer.sv
// Directed bench for uabc_msg_sequencer (TICK_DIV=8, DEBOUNCE_CYCLES=4, LAST_IDX=16).
module tb_uabc_msg_sequencer;

   logic clk;
   logic rst_n;
   logic ena;

   uabc_msg_sequencer_if sig ();

   uabc_msg_sequencer #(
      .TICK_DIV        (8),
      .DEBOUNCE_CYCLES (4),
      .LAST_IDX        (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .sig   (sig)
   );

   // Clock: 10 ns period, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int exp_idx = 0;
   bit watch_zero = 0;
   bit saw_zero = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock. Outputs are sampled 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
      if (watch_zero && sig.letter_idx == 5'd0) saw_zero = 1'b1;
   endtask

   // Wait for the next advance pulse, bounded. exp_n > 0 also checks the
   // number of edges taken, counted from pre.
   task automatic wait_adv(input string tag, input int exp_n, input int pre);
      int n;
      bit seen;
      n = pre;
      seen = 1'b0;
      while (!seen && n < pre + 40) begin
         step();
         n++;
         if (sig.advance === 1'b1) seen = 1'b1;
      end
      check({tag, "_seen"}, int'(seen), 1);
      if (exp_n > 0) check({tag, "_period"}, n, exp_n);
      exp_idx = (exp_idx == 16) ? 1 : exp_idx + 1;
      check({tag, "_idx"}, int'(sig.letter_idx), exp_idx);
   endtask

   // One clean press while paused: held 8 cycles, then released 8 cycles.
   task automatic press_step(input string tag);
      int na;
      int first;
      na = 0;
      first = 0;
      sig.step_btn = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         if (i == 9) sig.step_btn = 1'b0;
         step();
         if (sig.advance === 1'b1) begin
            na++;
            if (first == 0) first = i;
         end
      end
      check({tag, "_count"}, na, 1);
      check({tag, "_lat"}, first, 6);
      exp_idx = (exp_idx == 16) ? 1 : exp_idx + 1;
      check({tag, "_idx"}, int'(sig.letter_idx), exp_idx);
      check({tag, "_state"}, int'(sig.state), 2);
   endtask

   initial begin
      int na;

      rst_n        = 1'b0;
      ena          = 1'b1;
      sig.run_sw   = 1'b0;
      sig.pause_sw = 1'b0;
      sig.step_btn = 1'b0;
      sig.fast_sw  = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", int'(sig.state), 0);
      check("rst_idx", int'(sig.letter_idx), 0);
      check("rst_adv", int'(sig.advance), 0);
      #2 rst_n = 1'b1;
      repeat (4) step();
      check("idle_hold", int'(sig.state), 0);

      // Start: RUN and letter 1 exactly 6 edges after the pin change
      sig.run_sw = 1'b1;
      repeat (5) step();
      check("run_pre_state", int'(sig.state), 0);
      step();
      check("run_state", int'(sig.state), 1);
      check("run_idx", int'(sig.letter_idx), 1);
      check("run_adv", int'(sig.advance), 1);
      exp_idx = 1;

      // Scroll 1 -> 16 every 8 cycles, then wrap to 1 without passing 0
      watch_zero = 1'b1;
      for (int i = 0; i < 16; i++) wait_adv($sformatf("scroll%0d", i), 8, 0);
      watch_zero = 1'b0;
      check("wrap_no_zero", int'(saw_zero), 0);

      // Fast mode. The count is already past the new limit, so it ticks at once.
      sig.fast_sw = 1'b1;
      wait_adv("fast_first", 6, 0);
      wait_adv("fast_a", 4, 0);
      wait_adv("fast_b", 4, 0);
      sig.fast_sw = 1'b0;
      for (int i = 0; i < 3; i++) wait_adv($sformatf("settle%0d", i), -1, 0);
      wait_adv("slow_again", 8, 0);

      // A 3-cycle glitch on fast_sw leaves the period at 8
      sig.fast_sw = 1'b1;
      repeat (3) step();
      sig.fast_sw = 1'b0;
      wait_adv("glitch_a", 8, 3);
      wait_adv("glitch_b", 8, 0);

      // Pause: letter frozen, then each press gives exactly one advance
      sig.pause_sw = 1'b1;
      na = 0;
      repeat (5) begin
         step();
         if (sig.advance === 1'b1) na++;
      end
      check("pause_pre_state", int'(sig.state), 1);
      step();
      if (sig.advance === 1'b1) na++;
      check("pause_state", int'(sig.state), 2);
      check("pause_idx", int'(sig.letter_idx), exp_idx);
      check("pause_no_adv", na, 0);
      press_step("press1");
      press_step("press2");
      press_step("press3");

      // Back to RUN. step_btn pressed here must not shorten the 8-cycle tick.
      sig.pause_sw = 1'b0;
      repeat (6) step();
      check("resume_state", int'(sig.state), 1);
      sig.step_btn = 1'b1;
      wait_adv("run_step", 8, 0);
      sig.step_btn = 1'b0;
      wait_adv("pre_stop", 8, 0);

      // run_db falls in the cycle that also carries a tick
      repeat (2) step();
      sig.run_sw = 1'b0;
      repeat (5) step();
      check("stop_pre_state", int'(sig.state), 1);
      step();
      check("stop_state", int'(sig.state), 0);
      check("stop_idx", int'(sig.letter_idx), 0);
      check("stop_adv", int'(sig.advance), 0);

      // Restart, then hold ena low for 20 cycles mid-count
      sig.run_sw = 1'b1;
      repeat (6) step();
      check("rerun_idx", int'(sig.letter_idx), 1);
      exp_idx = 1;
      repeat (3) step();
      ena = 1'b0;
      na = 0;
      repeat (20) begin
         step();
         if (sig.advance === 1'b1) na++;
      end
      check("ena_adv", na, 0);
      check("ena_idx", int'(sig.letter_idx), 1);
      check("ena_state", int'(sig.state), 1);
      ena = 1'b1;
      wait_adv("ena_resume", 5, 0);

      // Short asynchronous reset pulse between edges during RUN
      repeat (2) step();
      #2 rst_n = 1'b0;
      #1;
      check("arst_state", int'(sig.state), 0);
      check("arst_idx", int'(sig.letter_idx), 0);
      check("arst_adv", int'(sig.advance), 0);
      rst_n = 1'b1;
      repeat (5) step();
      check("post_rst_pre", int'(sig.state), 0);
      step();
      check("post_rst_state", int'(sig.state), 1);
      check("post_rst_idx", int'(sig.letter_idx), 1);
      check("post_rst_adv", int'(sig.advance), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uabc_msg_sequencer.md
UABC_MSG_SEQUENCER -- requirements
Module: uabc_msg_sequencer

Upstream stage of the 7-segment letter-scroller: conditions the board switches and produces the letter index the segment stage decodes.

Interface
REQ-001 Parameter TICK_DIV, default 5_000_000, clk cycles per letter advance at normal speed.
REQ-002 Parameter DEBOUNCE_CYCLES, default 10_000, consecutive stable samples required to accept a switch change.
REQ-003 Parameter LAST_IDX, default 16, highest letter index before wrap.
REQ-004 clk  input  1  single clock; all registers on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 ena  input  1  design enable; low freezes every register except the synchronizers.
REQ-007 run_sw  input  1  raw run switch; 1 = scroll active, 0 = blank.
REQ-008 pause_sw  input  1  raw pause switch; 1 = hold the current letter.
REQ-009 step_btn  input  1  raw push-button; advances one letter while paused.
REQ-010 fast_sw  input  1  raw speed select; 1 = double advance rate.
REQ-011 letter_idx  output  5  current letter index, 0 = blank, 1..LAST_IDX = message letters.
REQ-012 advance  output  1  one-cycle pulse, high in the same cycle letter_idx takes its new advanced value.
REQ-013 state  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE; 11 never driven.

Function
REQ-014 Each raw input shall pass through a 2-flop synchronizer before any other logic.
REQ-015 Each synchronized input shall have a debounced register plus counter: counter clears when synchronized value equals debounced value, else increments; on reaching DEBOUNCE_CYCLES the debounced value takes the synchronized value and the counter clears.
REQ-016 Pin-to-debounced latency shall be exactly 2 + DEBOUNCE_CYCLES rising edges for a clean level change; a glitch shorter than DEBOUNCE_CYCLES synchronized cycles shall produce no change.
REQ-017 step_btn edge detect shall produce a one-cycle step_rise on 0->1 of the debounced step value only.
REQ-018 Prescaler shall count 0..T-1, T = TICK_DIV when fast_db=0 and TICK_DIV/2 when fast_db=1, asserting internal tick for one cycle at T-1 then wrapping to 0.
REQ-019 Prescaler shall run only in RUN and shall be held at 0 in IDLE and PAUSE; a fast_db change mid-count shall take effect on the next compare, and a count already >= new T-1 shall tick immediately and wrap.
REQ-020 FSM, highest priority first: run_db=0 -> IDLE from any state; IDLE & run_db=1 -> RUN; RUN & pause_db=1 -> PAUSE; PAUSE & pause_db=0 -> RUN; otherwise hold.
REQ-021 In IDLE letter_idx shall be 0 and advance 0.
REQ-022 On entering RUN from IDLE letter_idx shall become 1 in the same transition edge, with advance high for that cycle.
REQ-023 In RUN each tick shall advance letter_idx; in PAUSE each step_rise shall advance letter_idx; step_rise in RUN or IDLE shall be ignored.
REQ-024 Advance rule: letter_idx == LAST_IDX -> 1, otherwise +1; index 0 is reachable only through IDLE.
REQ-025 Tick in the same cycle as RUN->PAUSE transition shall still advance; tick or step_rise in the same cycle as run_db falling shall be discarded, letter_idx -> 0.
REQ-026 With ena=0 FSM, prescaler, debounce counters, debounced values, letter_idx shall hold; advance shall be 0.

Reset
REQ-027 rst_n low shall asynchronously force synchronizers, debounced values, all counters to 0, state to IDLE, letter_idx to 0, advance to 0.
REQ-028 Reset deassertion mid-scroll shall restart in IDLE; RUN is re-entered only after run_db is re-accepted through the full debounce latency.

Verification (TICK_DIV=8, DEBOUNCE_CYCLES=4, LAST_IDX=16)
REQ-029 Reset, run_sw=1 held -> state 01 and letter_idx=1 with advance pulse 6 edges after the pin change, then letter_idx +1 every 8 cycles.
REQ-030 Scroll to 16 -> next tick gives letter_idx=1, advance high one cycle, never 0.
REQ-031 fast_sw=1 in RUN -> advance period 4 cycles after debounce; 3-cycle glitch on fast_sw -> period stays 8.
REQ-032 pause_sw=1 -> state 10, letter_idx frozen; three clean step_btn presses -> exactly three advances; step_btn pressed in RUN -> no advance.
REQ-033 run_sw falling aligned so run_db drops on a tick cycle -> state 00, letter_idx=0, advance 0.
REQ-034 rst_n pulsed low for 1 ns between clock edges during RUN -> outputs 0/IDLE immediately; ena=0 for 20 cycles in RUN -> letter_idx and prescaler unchanged, resume on the same count.
